// File: rtl/cpu_control_pkg.sv
// Shared definitions for the 8-bit CPU sequencer: instruction classes,
// sequencer states, flag bit positions and the ALU operation codes.
package cpu_control_pkg;

  // Instruction classes (IR[7:4]); every unlisted class behaves as a NOP.
  localparam logic [3:0] CLS_ALU_REG = 4'h0;
  localparam logic [3:0] CLS_ALU_IMM = 4'h1;
  localparam logic [3:0] CLS_JMP     = 4'h2;
  localparam logic [3:0] CLS_JZ      = 4'h3;
  localparam logic [3:0] CLS_JC      = 4'h4;
  localparam logic [3:0] CLS_JN      = 4'h5;
  localparam logic [3:0] CLS_HALT    = 4'hF;

  // Bit positions inside the {N,V,C,Z} flags register.
  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 3;

  // ALU operation codes shared with cpu_alu.
  localparam logic [3:0] OP_ADD         = 4'h0;
  localparam logic [3:0] OP_SUB         = 4'h1;
  localparam logic [3:0] OP_AND         = 4'h2;
  localparam logic [3:0] OP_OR          = 4'h3;
  localparam logic [3:0] OP_XOR         = 4'h4;
  localparam logic [3:0] OP_PASS_B      = 4'h5;
  localparam logic [3:0] OP_MOVE_REG_XA = 4'h6;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_BOOT    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_OPERAND = 3'd3,
    ST_EXECUTE = 3'd4,
    ST_HALT    = 3'd5
  } state_t;

  // Classes that carry a second (imm8 / abs8) byte.
  function automatic logic has_operand(input logic [3:0] cls);
    return (cls == CLS_ALU_IMM) || (cls == CLS_JMP) || (cls == CLS_JZ) ||
           (cls == CLS_JC) || (cls == CLS_JN);
  endfunction

  // Classes whose execute writes back ALU result and flags.
  function automatic logic is_alu_class(input logic [3:0] cls);
    return (cls == CLS_ALU_REG) || (cls == CLS_ALU_IMM);
  endfunction

endpackage

// File: rtl/cpu_control_pc.sv
// Program counter: reset value, +1 increment (wrapping at 8 bits) and a
// load port that takes priority over the increment.
module cpu_control_pc
  import cpu_control_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] pc
);

  logic [7:0] pc_reg;
  logic [7:0] pc_next;

  // Next PC: a jump load wins, otherwise optional wrap-around increment.
  always_comb begin
    pc_next = pc_reg;
    if (load) begin
      pc_next = load_val;
    end else if (inc) begin
      pc_next = pc_reg + 8'd1;
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

  assign pc = pc_reg;

endmodule

// File: rtl/cpu_control.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU. Owns PC,
// A, X, IR, operand and flags registers, fetches over a request/ready port
// and drives the external ALU, writing its result and flags back.
module cpu_control
  import cpu_control_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic       mem_req_o,
  output logic [7:0] mem_addr_o,
  input  logic [7:0] mem_rdata_i,
  input  logic       mem_ready_i,
  output logic [7:0] alu_a_o,
  output logic [7:0] alu_b_o,
  output logic [3:0] alu_op_o,
  input  logic [7:0] alu_y_i,
  input  logic       alu_z_i,
  input  logic       alu_c_i,
  input  logic       alu_v_i,
  input  logic       alu_n_i,
  output logic [7:0] pc_o,
  output logic [7:0] a_o,
  output logic [7:0] x_o,
  output logic [3:0] flags_o,
  output logic       halted_o
);

  state_t     state_reg;
  state_t     state_next;
  logic [7:0] ir_reg;
  logic [7:0] opr_reg;
  logic [7:0] a_reg;
  logic [7:0] x_reg;
  logic [3:0] flags_reg;
  logic [3:0] alu_flags;
  logic [3:0] cls;
  logic [7:0] pc;
  logic       pc_inc;
  logic       pc_load;
  logic       jump_taken;
  logic       fetch_done;
  logic       operand_done;
  logic       alu_writeback;

  assign cls           = ir_reg[7:4];
  assign fetch_done    = (state_reg == ST_FETCH) && mem_ready_i;
  assign operand_done  = (state_reg == ST_OPERAND) && mem_ready_i;
  assign alu_writeback = (state_reg == ST_EXECUTE) && is_alu_class(cls);

  assign alu_flags[FLAG_Z] = alu_z_i;
  assign alu_flags[FLAG_C] = alu_c_i;
  assign alu_flags[FLAG_V] = alu_v_i;
  assign alu_flags[FLAG_N] = alu_n_i;

  cpu_control_pc #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .inc      (pc_inc),
    .load     (pc_load),
    .load_val (opr_reg),
    .pc       (pc)
  );

  // Branch decision on the registered flags; JMP is always taken.
  always_comb begin
    jump_taken = 1'b0;
    case (cls)
      CLS_JMP: jump_taken = 1'b1;
      CLS_JZ:  jump_taken = flags_reg[FLAG_Z];
      CLS_JC:  jump_taken = flags_reg[FLAG_C];
      CLS_JN:  jump_taken = flags_reg[FLAG_N];
      default: jump_taken = 1'b0;
    endcase
  end

  // Sequencer state register; reset lands in BOOT which drops the request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= ST_BOOT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state, memory request and PC control.
  always_comb begin
    state_next = state_reg;
    mem_req_o  = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    case (state_reg)
      ST_BOOT: state_next = ST_FETCH;
      ST_FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          pc_inc     = 1'b1;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (has_operand(cls)) begin
          state_next = ST_OPERAND;
        end else if (cls == CLS_HALT) begin
          state_next = ST_HALT;
        end else begin
          state_next = ST_EXECUTE;
        end
      end
      ST_OPERAND: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          pc_inc     = 1'b1;
          state_next = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        pc_load    = jump_taken;
        state_next = ST_FETCH;
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_BOOT;
    endcase
  end

  // Instruction and operand byte capture on completed fetches.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ir_reg  <= 8'h00;
      opr_reg <= 8'h00;
    end else begin
      if (fetch_done) begin
        ir_reg <= mem_rdata_i;
      end
      if (operand_done) begin
        opr_reg <= mem_rdata_i;
      end
    end
  end

  // ALU writeback: X for the move op, A otherwise; flags taken as reported.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_reg     <= 8'h00;
      x_reg     <= 8'h00;
      flags_reg <= 4'h0;
    end else if (alu_writeback) begin
      if (ir_reg[3:0] == OP_MOVE_REG_XA) begin
        x_reg <= alu_y_i;
      end else begin
        a_reg <= alu_y_i;
      end
      flags_reg <= alu_flags;
    end
  end

  assign mem_addr_o = pc;
  assign alu_a_o    = a_reg;
  assign alu_b_o    = (cls == CLS_ALU_REG) ? x_reg : opr_reg;
  assign alu_op_o   = ir_reg[3:0];
  assign pc_o       = pc;
  assign a_o        = a_reg;
  assign x_o        = x_reg;
  assign flags_o    = flags_reg;
  assign halted_o   = (state_reg == ST_HALT);

endmodule

// File: tb/tb_cpu_control.sv
// Self-checking bench for cpu_control: an instruction-level interpreter
// predicts fetch addresses, per-instruction cycle counts and architectural
// state, while a behavioural ALU and a random-wait memory drive the DUT.
module tb_cpu_control;
  import cpu_control_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       mem_req_o;
  logic [7:0] mem_addr_o;
  logic [7:0] mem_rdata_i;
  logic       mem_ready_i;
  logic [7:0] alu_a_o;
  logic [7:0] alu_b_o;
  logic [3:0] alu_op_o;
  logic [7:0] alu_y_i;
  logic       alu_z_i;
  logic       alu_c_i;
  logic       alu_v_i;
  logic       alu_n_i;
  logic [7:0] pc_o;
  logic [7:0] a_o;
  logic [7:0] x_o;
  logic [3:0] flags_o;
  logic       halted_o;

  always #5 clk_i = ~clk_i;

  cpu_control #(.RESET_PC(8'h00)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ready_i (mem_ready_i),
    .alu_a_o     (alu_a_o),
    .alu_b_o     (alu_b_o),
    .alu_op_o    (alu_op_o),
    .alu_y_i     (alu_y_i),
    .alu_z_i     (alu_z_i),
    .alu_c_i     (alu_c_i),
    .alu_v_i     (alu_v_i),
    .alu_n_i     (alu_n_i),
    .pc_o        (pc_o),
    .a_o         (a_o),
    .x_o         (x_o),
    .flags_o     (flags_o),
    .halted_o    (halted_o)
  );

  logic [7:0] mem [256];
  int tests_run    = 0;
  int tests_failed = 0;

  // Interpreter state
  logic [7:0] m_pc;
  logic [7:0] m_a;
  logic [7:0] m_x;
  logic [3:0] m_flags;
  bit         m_halted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      if (tests_failed <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural ALU: returns {n,v,c,z,y}
  function automatic logic [11:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] y;
    logic c;
    logic v;
    c = 1'b0;
    v = 1'b0;
    y = a;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        y = s[7:0];
        c = s[8];
        v = (a[7] == b[7]) && (y[7] != a[7]);
      end
      OP_SUB: begin
        y = a - b;
        c = (a < b);
        v = (a[7] != b[7]) && (y[7] != a[7]);
      end
      OP_AND:         y = a & b;
      OP_OR:          y = a | b;
      OP_XOR:         y = a ^ b;
      OP_PASS_B:      y = b;
      OP_MOVE_REG_XA: y = a;
      default: begin
        y = {a[6:0], a[7]} ^ b;
        c = a[7];
      end
    endcase
    return {y[7], v, c, (y == 8'h00), y};
  endfunction

  logic [11:0] alu_r;
  assign alu_r = alu_ref(alu_op_o, alu_a_o, alu_b_o);
  assign {alu_n_i, alu_v_i, alu_c_i, alu_z_i, alu_y_i} = alu_r;

  function automatic bit needs_opr(input logic [7:0] opc);
    return (opc[7:4] >= 4'h1) && (opc[7:4] <= 4'h5);
  endfunction

  // One instruction of the ISA, applied to the interpreter state.
  task automatic model_exec(input logic [7:0] opc, input logic [7:0] opr);
    logic [11:0] r;
    case (opc[7:4])
      4'h0, 4'h1: begin
        r = alu_ref(opc[3:0], m_a, (opc[7:4] == 4'h0) ? m_x : opr);
        if (opc[3:0] == OP_MOVE_REG_XA) m_x = r[7:0];
        else m_a = r[7:0];
        m_flags = r[11:8];
      end
      4'h2: m_pc = opr;
      4'h3: if (m_flags[0]) m_pc = opr;
      4'h4: if (m_flags[1]) m_pc = opr;
      4'h5: if (m_flags[3]) m_pc = opr;
      4'hF: m_halted = 1'b1;
      default: ;
    endcase
  endtask

  task automatic load_directed();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h15; mem[8'h01] = 8'h7F;   // A = 7F
    mem[8'h02] = 8'h10; mem[8'h03] = 8'h01;   // A = 80, N V
    mem[8'h04] = 8'h15; mem[8'h05] = 8'h05;   // A = 05
    mem[8'h06] = 8'h06;                       // X = A
    mem[8'h07] = 8'h01;                       // A = A - X -> 0, Z
    mem[8'h08] = 8'h37; mem[8'h09] = 8'h40;   // JZ 40 (taken)
    mem[8'h40] = 8'h20; mem[8'h41] = 8'h10;   // JMP 10
    mem[8'h10] = 8'h40; mem[8'h11] = 8'h40;   // JC 40 (not taken)
    mem[8'h12] = 8'h7A;                       // NOP
    mem[8'h13] = 8'h50; mem[8'h14] = 8'h30;   // JN 30 (not taken)
    mem[8'h15] = 8'h20; mem[8'h16] = 8'hFF;   // JMP FF
    mem[8'hFF] = 8'h00;                       // A = A + X, wraps to 00
  endtask

  task automatic load_halt();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h15; mem[1] = 8'h33;
    mem[2] = 8'h06;
    mem[3] = 8'hF5;
  endtask

  task automatic load_random();
    logic [7:0] b;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 9) < 7) b[7:4] = 4'($urandom_range(0, 5));
      if (b[7:4] == 4'hF && $urandom_range(0, 19) != 0) b[7:4] = 4'h0;
      mem[i] = b;
    end
  endtask

  // Hold reset, check reset values, release and check the BOOT cycle.
  task automatic do_reset(input string name);
    rst_ni      = 1'b0;
    mem_ready_i = 1'b0;
    mem_rdata_i = 8'h00;
    repeat (2) @(negedge clk_i);
    check({name, "/rst_req"},    mem_req_o, 1'b0);
    check({name, "/rst_halted"}, halted_o, 1'b0);
    check({name, "/rst_pc"},     pc_o, 8'h00);
    check({name, "/rst_a"},      a_o, 8'h00);
    check({name, "/rst_x"},      x_o, 8'h00);
    check({name, "/rst_flags"},  flags_o, 4'h0);
    check({name, "/rst_aluop"},  alu_op_o, 4'h0);
    check({name, "/rst_alub"},   alu_b_o, 8'h00);
    rst_ni = 1'b1;
    #1;
    check({name, "/boot_req"}, mem_req_o, 1'b0);
    @(posedge clk_i);
    #1;
    check({name, "/first_req"},  mem_req_o, 1'b1);
    check({name, "/first_addr"}, mem_addr_o, 8'h00);
  endtask

  // Drive memory with random wait states and check every instruction
  // boundary against the interpreter. rst_at > 0 pulses reset during the
  // operand fetch once that many opcodes have been fetched.
  task automatic run_phase(input string name, input int max_instr, input int ready_pct, input int rst_at);
    int         since;
    int         waits;
    int         cyc;
    int         n_instr;
    int         exp_lat;
    int         budget;
    bit         want_opr;
    bit         first;
    bit         done;
    bit         prev_stall;
    logic       req;
    logic       rdy;
    logic [7:0] addr;
    logic [7:0] prev_addr;
    logic [7:0] opc;
    m_pc = 8'h00; m_a = 8'h00; m_x = 8'h00; m_flags = 4'h0; m_halted = 1'b0;
    since = 0; waits = 0; cyc = 0; n_instr = 0; exp_lat = 0;
    budget = max_instr * 40 + 100;
    want_opr = 1'b0; first = 1'b1; done = 1'b0; prev_stall = 1'b0;
    prev_addr = 8'h00; opc = 8'h00;
    while (!done) begin
      @(negedge clk_i);
      cyc++;
      since++;
      req  = mem_req_o;
      addr = mem_addr_o;
      if (prev_stall) begin
        check({name, "/stall_req"},  req, 1'b1);
        check({name, "/stall_addr"}, addr, prev_addr);
      end
      if (m_halted) begin
        if (since == 1) check({name, "/decode_not_halted"}, halted_o, 1'b0);
        if (since >= 2) begin
          check({name, "/halted"},   halted_o, 1'b1);
          check({name, "/halt_req"}, req, 1'b0);
        end
        if (since >= 12) begin
          check({name, "/halt_a"},     a_o, m_a);
          check({name, "/halt_x"},     x_o, m_x);
          check({name, "/halt_flags"}, flags_o, m_flags);
          check({name, "/halt_pc"},    pc_o, m_pc);
          done = 1'b1;
        end
      end
      if (!done && rst_at > 0 && want_opr && n_instr >= rst_at && req) begin
        mem_ready_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        check({name, "/async_req"},   mem_req_o, 1'b0);
        check({name, "/async_pc"},    pc_o, 8'h00);
        check({name, "/async_a"},     a_o, 8'h00);
        check({name, "/async_x"},     x_o, 8'h00);
        check({name, "/async_flags"}, flags_o, 4'h0);
        $display("[TB] %s: reset during operand fetch at 0x%0h, A was 0x%0h", name, addr, m_a);
        done = 1'b1;
      end
      if (!done) begin
        rdy = ($urandom_range(0, 99) < ready_pct);
        mem_ready_i = rdy;
        mem_rdata_i = rdy ? mem[addr] : 8'($urandom);
        prev_stall  = req && !rdy;
        prev_addr   = addr;
        if (prev_stall) waits++;
        if (!m_halted && req && rdy) begin
          check({name, "/fetch_addr"}, addr, m_pc);
          check({name, "/pc_out"},     pc_o, m_pc);
          if (!want_opr) begin
            if (!first) begin
              check({name, "/latency"}, since, exp_lat + waits);
              check({name, "/a"},       a_o, m_a);
              check({name, "/x"},       x_o, m_x);
              check({name, "/flags"},   flags_o, m_flags);
            end
            first = 1'b0;
            n_instr++;
            opc = mem[addr];
            $display("[TB] %s #%0d pc=0x%02h op=0x%02h A=0x%02h X=0x%02h F=0x%0h", name, n_instr, addr, opc, m_a, m_x, m_flags);
            if (n_instr > max_instr) begin
              done = 1'b1;
            end else begin
              m_pc    = m_pc + 8'd1;
              since   = 0;
              waits   = 0;
              exp_lat = needs_opr(opc) ? 4 : 3;
              if (needs_opr(opc)) want_opr = 1'b1;
              else model_exec(opc, 8'h00);
            end
          end else begin
            m_pc = m_pc + 8'd1;
            model_exec(opc, mem[addr]);
            want_opr = 1'b0;
          end
        end
        if (!done && cyc > budget) begin
          check({name, "/timeout_instr"}, n_instr, max_instr + 1);
          done = 1'b1;
        end
      end
    end
    mem_ready_i = 1'b0;
  endtask

  int pct [4] = '{100, 70, 40, 85};

  initial begin
    rst_ni      = 1'b0;
    mem_ready_i = 1'b0;
    mem_rdata_i = 8'h00;

    load_directed();
    do_reset("dir");
    run_phase("dir", 14, 100, 0);

    load_directed();
    do_reset("wait");
    run_phase("wait", 14, 40, 0);

    load_halt();
    do_reset("halt");
    run_phase("halt", 10, 50, 0);

    load_directed();
    do_reset("rstop");
    run_phase("rstop", 20, 70, 3);

    for (int p = 0; p < 4; p++) begin
      load_random();
      do_reset("rnd");
      run_phase("rnd", 80, pct[p], 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
